// File: rtl/status_flags.sv
// status_flags: 6502 P register with NMI/IRQ sampling; `define DECIMAL_EN keeps the D flag (else 2A03-style, D=0)
module status_flags (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       RDY,
  input  logic       ALU_C,
  input  logic       ALU_V,
  input  logic       ALU_Z,
  input  logic       ALU_N,
  input  logic       LOAD_C,
  input  logic       LOAD_V,
  input  logic       LOAD_ZN,
  input  logic       BIT_OP,
  input  logic       PLP,
  input  logic [7:0] DI,
  input  logic       SEC,
  input  logic       CLC,
  input  logic       SED,
  input  logic       CLD,
  input  logic       SEI,
  input  logic       CLI,
  input  logic       CLV,
  input  logic       INT_TAKE,
  input  logic       PUSH_B,
  input  logic       NMI_N,
  input  logic       IRQ_N,
  output logic [7:0] P,
  output logic       D_FLAG,
  output logic       INT_REQ,
  output logic       INT_NMI
);
  logic c, z, i, v, n, d;
  logic c_nx, z_nx, i_nx, v_nx, n_nx;
  logic nmi_s1, nmi_s, irq_s1, irq_s, nmi_prev, nmi_pend;
  logic nmi_fall, irq_act;
  always_comb begin
    c_nx = PLP ? DI[0] : SEC ? 1'b1 : CLC ? 1'b0 : LOAD_C ? ALU_C : c;
    z_nx = PLP ? DI[1] : (BIT_OP | LOAD_ZN) ? ALU_Z : z;
    i_nx = INT_TAKE ? 1'b1 : PLP ? DI[2] : SEI ? 1'b1 : CLI ? 1'b0 : i;
    v_nx = PLP ? DI[6] : CLV ? 1'b0 : BIT_OP ? DI[6] : LOAD_V ? ALU_V : v;
    n_nx = PLP ? DI[7] : BIT_OP ? DI[7] : LOAD_ZN ? ALU_N : n;
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      {c, z, v, n} <= 4'b0;
      i <= 1'b1;
    end else if (RDY) begin
      {c, z, i, v, n} <= {c_nx, z_nx, i_nx, v_nx, n_nx};
    end
`ifdef DECIMAL_EN
  logic unused_di;
  assign unused_di = ^DI[5:4];
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) d <= 1'b0;
    else if (RDY) d <= PLP ? DI[3] : SED ? 1'b1 : CLD ? 1'b0 : d;
`else
  logic unused_dec;
  assign unused_dec = ^{DI[5:3], SED, CLD};
  assign d = 1'b0;
`endif
  // NMI edge capture runs regardless of RDY; only the acknowledge is stalled
  assign nmi_fall = nmi_prev & ~nmi_s;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      {nmi_s1, nmi_s, irq_s1, irq_s, nmi_prev} <= 5'b11111;
      nmi_pend <= 1'b0;
    end else begin
      {nmi_s1, nmi_s} <= {NMI_N, nmi_s1};
      {irq_s1, irq_s} <= {IRQ_N, irq_s1};
      nmi_prev <= nmi_s;
      nmi_pend <= nmi_fall | (nmi_pend & ~(RDY & INT_TAKE));
    end
  assign irq_act = ~irq_s & ~i;
  assign P       = {n, v, 1'b1, PUSH_B, d, i, z, c};
  assign D_FLAG  = d;
  assign INT_REQ = nmi_pend | irq_act;
  assign INT_NMI = nmi_pend;
endmodule

// File: tb/tb_status_flags.sv
// tb_status_flags: directed self-checking bench for status_flags
module tb_status_flags;
  logic CLK = 0, RST_N = 0, RDY = 1;
  logic ALU_C = 0, ALU_V = 0, ALU_Z = 0, ALU_N = 0;
  logic LOAD_C = 0, LOAD_V = 0, LOAD_ZN = 0, BIT_OP = 0, PLP = 0;
  logic [7:0] DI = 0;
  logic SEC = 0, CLC = 0, SED = 0, CLD = 0, SEI = 0, CLI = 0, CLV = 0;
  logic INT_TAKE = 0, PUSH_B = 0, NMI_N = 1, IRQ_N = 1;
  logic [7:0] P;
  logic D_FLAG, INT_REQ, INT_NMI;
  int vectors = 0, miscompares = 0;
`ifdef DECIMAL_EN
  localparam logic [7:0] PLP_FF = 8'hEF;
  localparam logic       D_FF   = 1'b1;
`else
  localparam logic [7:0] PLP_FF = 8'hE7;
  localparam logic       D_FF   = 1'b0;
`endif

  status_flags dut (
    .CLK(CLK), .RST_N(RST_N), .RDY(RDY),
    .ALU_C(ALU_C), .ALU_V(ALU_V), .ALU_Z(ALU_Z), .ALU_N(ALU_N),
    .LOAD_C(LOAD_C), .LOAD_V(LOAD_V), .LOAD_ZN(LOAD_ZN), .BIT_OP(BIT_OP),
    .PLP(PLP), .DI(DI), .SEC(SEC), .CLC(CLC), .SED(SED), .CLD(CLD),
    .SEI(SEI), .CLI(CLI), .CLV(CLV), .INT_TAKE(INT_TAKE), .PUSH_B(PUSH_B),
    .NMI_N(NMI_N), .IRQ_N(IRQ_N), .P(P), .D_FLAG(D_FLAG),
    .INT_REQ(INT_REQ), .INT_NMI(INT_NMI)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int k = 1);
    repeat (k) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST_N = 0;
    step(2);
    vectors++; if (P !== 8'h24) begin miscompares++; $display("FAIL reset_p got %h want 24", P); end
    vectors++; if ({D_FLAG, INT_REQ, INT_NMI} !== 3'b000) begin miscompares++; $display("FAIL reset_out got %b want 000", {D_FLAG, INT_REQ, INT_NMI}); end
    PUSH_B = 1; #1;
    vectors++; if (P !== 8'h34) begin miscompares++; $display("FAIL reset_push_b got %h want 34", P); end
    PUSH_B = 0;
    RST_N = 1;
    step();
    vectors++; if (P !== 8'h24 || INT_REQ !== 0) begin miscompares++; $display("FAIL release got P=%h req=%b want 24/0", P, INT_REQ); end
  endtask

  task automatic test_load;
    ALU_C = 1; ALU_Z = 1; ALU_N = 0; LOAD_C = 1; LOAD_ZN = 1; RDY = 0;
    step();
    vectors++; if (P !== 8'h24) begin miscompares++; $display("FAIL load_stall got %h want 24", P); end
    RDY = 1;
    step();
    vectors++; if (P !== 8'h27) begin miscompares++; $display("FAIL load_czn got %h want 27", P); end
    LOAD_C = 0; LOAD_ZN = 0;
    DI = 8'hC0; ALU_Z = 0; BIT_OP = 1;
    step();
    vectors++; if (P !== 8'hE5) begin miscompares++; $display("FAIL bit_op got %h want e5", P); end
    BIT_OP = 0; CLV = 1; ALU_V = 1; LOAD_V = 1;
    step();
    vectors++; if (P !== 8'hA5) begin miscompares++; $display("FAIL clv_over_load got %h want a5", P); end
    CLV = 0; LOAD_V = 0; ALU_V = 0;
  endtask

  task automatic test_plp;
    DI = 8'hFF; PLP = 1;
    step();
    vectors++; if (P !== PLP_FF) begin miscompares++; $display("FAIL plp_ff got %h want %h", P, PLP_FF); end
    vectors++; if (D_FLAG !== D_FF) begin miscompares++; $display("FAIL plp_d got %b want %b", D_FLAG, D_FF); end
    DI = 8'h00; SEC = 1;
    step();
    vectors++; if (P !== 8'h20) begin miscompares++; $display("FAIL plp_over_sec got %h want 20", P); end
    PLP = 0;
    step();
    vectors++; if (P !== 8'h21) begin miscompares++; $display("FAIL sec got %h want 21", P); end
    SEC = 0; CLC = 1;
    step();
    CLC = 0;
  endtask

  task automatic test_sei_cli;
    SEI = 1; CLI = 1;
    step();
    vectors++; if (P !== 8'h24) begin miscompares++; $display("FAIL sei_cli got %h want 24", P); end
    SEI = 0;
    step();
    CLI = 0;
    vectors++; if (P !== 8'h20) begin miscompares++; $display("FAIL cli got %h want 20", P); end
    IRQ_N = 0;
    step();
    vectors++; if (INT_REQ !== 0) begin miscompares++; $display("FAIL irq_early got %b want 0", INT_REQ); end
    step();
    vectors++; if ({INT_REQ, INT_NMI} !== 2'b10) begin miscompares++; $display("FAIL irq_req got %b want 10", {INT_REQ, INT_NMI}); end
    IRQ_N = 1;
    step();
    vectors++; if (INT_REQ !== 1) begin miscompares++; $display("FAIL irq_hold got %b want 1", INT_REQ); end
    step();
    vectors++; if (INT_REQ !== 0) begin miscompares++; $display("FAIL irq_withdraw got %b want 0", INT_REQ); end
    IRQ_N = 0;
    step(2);
    SEI = 1;
    step();
    SEI = 0;
    vectors++; if (INT_REQ !== 0) begin miscompares++; $display("FAIL irq_masked got %b want 0", INT_REQ); end
    IRQ_N = 1;
    step(2);
  endtask

  task automatic test_nmi;
    NMI_N = 0;
    step(2);
    vectors++; if (INT_REQ !== 0) begin miscompares++; $display("FAIL nmi_early got %b want 0", INT_REQ); end
    step();
    vectors++; if ({INT_REQ, INT_NMI} !== 2'b11) begin miscompares++; $display("FAIL nmi_req got %b want 11", {INT_REQ, INT_NMI}); end
    RDY = 0; INT_TAKE = 1;
    step();
    vectors++; if (INT_NMI !== 1) begin miscompares++; $display("FAIL nmi_stall_ack got %b want 1", INT_NMI); end
    RDY = 1;
    step();
    INT_TAKE = 0;
    vectors++; if ({INT_REQ, INT_NMI, P[2]} !== 3'b001) begin miscompares++; $display("FAIL nmi_ack got %b want 001", {INT_REQ, INT_NMI, P[2]}); end
    step(4);
    vectors++; if (INT_REQ !== 0) begin miscompares++; $display("FAIL nmi_once got %b want 0", INT_REQ); end
    NMI_N = 1;
    step(3);
    NMI_N = 0;
    step(3);
    vectors++; if (INT_NMI !== 1) begin miscompares++; $display("FAIL nmi_rearm got %b want 1", INT_NMI); end
  endtask

  task automatic test_async_reset;
    SEC = 1;
    step();
    SEC = 0;
    vectors++; if (P[0] !== 1 || INT_NMI !== 1) begin miscompares++; $display("FAIL pre_reset got c=%b nmi=%b want 1/1", P[0], INT_NMI); end
    #2 RST_N = 0;
    #1;
    vectors++; if (P !== 8'h24 || INT_REQ !== 0 || INT_NMI !== 0) begin miscompares++; $display("FAIL async_reset got P=%h req=%b nmi=%b want 24/0/0", P, INT_REQ, INT_NMI); end
    NMI_N = 1;
    step();
    RST_N = 1;
    step(3);
    vectors++; if (P !== 8'h24 || INT_REQ !== 0) begin miscompares++; $display("FAIL post_reset got P=%h req=%b want 24/0", P, INT_REQ); end
  endtask

  initial begin
    test_reset;
    test_load;
    test_plp;
    test_sei_cli;
    test_nmi;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
